// File: rtl/result_packer.sv
// result_packer: gathers lane results into beats, packs beats into SRAM words,
// buffers the words in a small FIFO and drains them over a req/gnt handshake
// with an auto-incrementing word address.
module result_packer #(
    parameter  int LANE_W         = 16,
    parameter  int N_LANES        = 2,
    parameter  int BEATS_PER_WORD = 1,
    parameter  int DEPTH          = 4,
    parameter  int ADDR_W         = 10,
    localparam int BEAT_W         = N_LANES * LANE_W,
    localparam int WORD_W         = BEATS_PER_WORD * BEAT_W,
    localparam int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              shift_out,
    input  logic [BEAT_W-1:0] res_in,
    input  logic              flush,
    output logic              in_ready,
    output logic              sram_req,
    input  logic              sram_gnt,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BI_W  = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;

    // FIFO pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    logic [BI_W-1:0]   beat_idx_q, beat_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              overflow_q, overflow_d;

    logic              in_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [WORD_W-1:0] packed_s;
    logic [WORD_W-1:0] push_word_s;
    logic [BI_W-1:0]   idx_next_s;
    logic              word_done_s;

    // Ready only depends on the registered count; a same-cycle pop does not help.
    assign in_ready_s = (count_q < CNT_W'(DEPTH));
    assign accept_s   = shift_out & in_ready_s;
    assign pop_s      = (count_q != CNT_W'(0)) & sram_gnt & ~start;

    // Packer: place the accepted beat, then decide whether a word is pushed.
    always_comb begin
        packed_s    = word_q;
        push_s      = 1'b0;
        push_word_s = '0;
        word_done_s = 1'b0;
        idx_next_s  = beat_idx_q;
        beat_idx_d  = beat_idx_q;
        word_d      = word_q;
        overflow_d  = overflow_q;
        if (accept_s) begin
            for (int k = 0; k < BEATS_PER_WORD; k++) begin
                if (beat_idx_q == BI_W'(k)) begin
                    packed_s[WORD_W-1-k*BEAT_W -: BEAT_W] = res_in;
                end else begin
                    packed_s[WORD_W-1-k*BEAT_W -: BEAT_W] = word_q[WORD_W-1-k*BEAT_W -: BEAT_W];
                end
            end
            word_done_s = (beat_idx_q == BI_W'(BEATS_PER_WORD - 1));
            idx_next_s  = beat_idx_q + BI_W'(1);
        end else begin
            word_done_s = 1'b0;
        end
        if (start) begin
            beat_idx_d = '0;
            word_d     = '0;
            overflow_d = 1'b0;
        end else if (word_done_s) begin
            // Completed word: a simultaneous flush has nothing left to close.
            push_s      = 1'b1;
            push_word_s = packed_s;
            beat_idx_d  = '0;
            word_d      = '0;
        end else if (flush && (idx_next_s != BI_W'(0))) begin
            if (!in_ready_s) begin
                // No room: keep the partial word and flag the loss of the flush.
                beat_idx_d = idx_next_s;
                word_d     = packed_s;
                overflow_d = 1'b1;
            end else begin
                // Unfilled beats are still zero because the buffer clears on push.
                push_s      = 1'b1;
                push_word_s = packed_s;
                beat_idx_d  = '0;
                word_d      = '0;
            end
        end else begin
            beat_idx_d = idx_next_s;
            word_d     = packed_s;
        end
        if (!start && shift_out && !in_ready_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_d;
        end
    end

    // FIFO bookkeeping and drain address; start empties the queue and reloads the address.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        if (start) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            addr_d   = base_addr;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = push_word_s;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                addr_d   = addr_q + ADDR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; async reset returns everything to idle and empty.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            beat_idx_q <= '0;
            word_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            beat_idx_q <= beat_idx_d;
            word_q     <= word_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs are straight decodes of registered state.
    always_comb begin
        in_ready   = in_ready_s;
        sram_req   = (count_q != CNT_W'(0));
        sram_addr  = addr_q;
        fifo_count = count_q;
        overflow   = overflow_q;
        if (count_q != CNT_W'(0)) begin
            sram_wdata = mem_q[rd_ptr_q];
        end else begin
            sram_wdata = '0;
        end
    end

endmodule

// File: tb/tb_result_packer.sv
// Bench for result_packer: two instances (1 and 2 beats per word) share the
// same stimulus; each is compared every cycle against a word-level queue model.
module tb_result_packer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              shift_out;
    logic [31:0]       res_in;
    logic              flush;
    logic              sram_gnt;

    logic              in_ready0, sram_req0, overflow0;
    logic [ADDR_W-1:0] sram_addr0;
    logic [31:0]       sram_wdata0;
    logic [2:0]        fifo_count0;
    logic              in_ready1, sram_req1, overflow1;
    logic [ADDR_W-1:0] sram_addr1;
    logic [63:0]       sram_wdata1;
    logic [2:0]        fifo_count1;

    int n_checks = 0;
    int n_pass   = 0;

    // model state, index 0 = one beat per word, index 1 = two beats per word
    int          bpw  [2] = '{1, 2};
    int          mcnt [2];
    logic [63:0] mw   [2][DEPTH];
    int          pcnt [2];
    logic [31:0] part [2][2];
    logic [9:0]  maddr[2];
    logic        mov  [2];

    always #5 CLK = ~CLK;

    result_packer #(.LANE_W(16), .N_LANES(2), .BEATS_PER_WORD(1), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut0 (
        .CLK(CLK), .RESET(RESET), .start(start), .base_addr(base_addr), .shift_out(shift_out),
        .res_in(res_in), .flush(flush), .in_ready(in_ready0), .sram_req(sram_req0),
        .sram_gnt(sram_gnt), .sram_addr(sram_addr0), .sram_wdata(sram_wdata0),
        .fifo_count(fifo_count0), .overflow(overflow0));

    result_packer #(.LANE_W(16), .N_LANES(2), .BEATS_PER_WORD(2), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut1 (
        .CLK(CLK), .RESET(RESET), .start(start), .base_addr(base_addr), .shift_out(shift_out),
        .res_in(res_in), .flush(flush), .in_ready(in_ready1), .sram_req(sram_req1),
        .sram_gnt(sram_gnt), .sram_addr(sram_addr1), .sram_wdata(sram_wdata1),
        .fifo_count(fifo_count1), .overflow(overflow1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] assemble(input int i);
        logic [63:0] w = 64'd0;
        for (int k = 0; k < pcnt[i]; k++) begin
            w = w | (64'(part[i][k]) << ((bpw[i] - 1 - k) * 32));
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; pcnt[i] = 0; maddr[i] = 10'd0; mov[i] = 1'b0;
        end
    endtask

    // One clock edge of the reference behaviour, using the currently driven inputs.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (start) begin
                mcnt[i] = 0; pcnt[i] = 0; maddr[i] = base_addr; mov[i] = 1'b0;
            end else begin
                bit full = (mcnt[i] >= DEPTH);
                bit do_push = 1'b0;
                logic [63:0] w = 64'd0;
                if (shift_out) begin
                    if (full) mov[i] = 1'b1;
                    else begin
                        part[i][pcnt[i]] = res_in;
                        pcnt[i]++;
                        if (pcnt[i] == bpw[i]) begin
                            w = assemble(i); do_push = 1'b1; pcnt[i] = 0;
                        end
                    end
                end
                if (flush && pcnt[i] != 0) begin
                    if (full) mov[i] = 1'b1;
                    else begin
                        w = assemble(i); do_push = 1'b1; pcnt[i] = 0;
                    end
                end
                if (mcnt[i] > 0 && sram_gnt) begin
                    for (int j = 0; j < DEPTH - 1; j++) mw[i][j] = mw[i][j+1];
                    mcnt[i]--;
                    maddr[i] = maddr[i] + 10'd1;
                end
                if (do_push) begin
                    mw[i][mcnt[i]] = w;
                    mcnt[i]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("in_ready0", 64'(in_ready0), 64'(mcnt[0] < DEPTH));
        check("req0",      64'(sram_req0), 64'(mcnt[0] != 0));
        check("addr0",     64'(sram_addr0), 64'(maddr[0]));
        check("wdata0",    64'(sram_wdata0), (mcnt[0] != 0) ? mw[0][0] : 64'd0);
        check("count0",    64'(fifo_count0), 64'(mcnt[0]));
        check("ovf0",      64'(overflow0), 64'(mov[0]));
        check("in_ready1", 64'(in_ready1), 64'(mcnt[1] < DEPTH));
        check("req1",      64'(sram_req1), 64'(mcnt[1] != 0));
        check("addr1",     64'(sram_addr1), 64'(maddr[1]));
        check("wdata1",    sram_wdata1, (mcnt[1] != 0) ? mw[1][0] : 64'd0);
        check("count1",    64'(fifo_count1), 64'(mcnt[1]));
        check("ovf1",      64'(overflow1), 64'(mov[1]));
    endtask

    task automatic drive(input bit st, input logic [9:0] base, input bit sh,
                         input logic [31:0] d, input bit fl, input bit g);
        start = st; base_addr = base; shift_out = sh; res_in = d; flush = fl; sram_gnt = g;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 10'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_outputs();
        check("rst_in_ready", 64'(in_ready0), 64'd1);
        @(negedge CLK);
        RESET = 1'b0;

        // basic word and drain, plus gnt without req on the 2-beat instance
        drive(1'b1, 10'h010, 1'b0, 32'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 10'h000, 1'b1, 32'h1234ABCD, 1'b0, 1'b0); tick();
        check("t1_wdata", 64'(sram_wdata0), 64'h1234ABCD);
        check("t1_addr", 64'(sram_addr0), 64'h010);
        check("t1_half", 64'(fifo_count1), 64'd0);
        drive(1'b0, 10'h000, 1'b0, 32'd0, 1'b0, 1'b1); tick();
        check("t1_addr_inc", 64'(sram_addr0), 64'h011);
        check("t1_req_low", 64'(sram_req0), 64'd0);

        // two beats packed into one word
        drive(1'b1, 10'h000, 1'b0, 32'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 10'h000, 1'b1, 32'hAAAA5555, 1'b0, 1'b0); tick();
        drive(1'b0, 10'h000, 1'b1, 32'h11112222, 1'b0, 1'b0); tick();
        check("t2_word", sram_wdata1, 64'hAAAA555511112222);

        // partial word flush, then a no-op flush
        drive(1'b1, 10'h000, 1'b0, 32'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 10'h000, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0); tick();
        drive(1'b0, 10'h000, 1'b0, 32'd0, 1'b1, 1'b0); tick();
        check("t3_flush", sram_wdata1, 64'hDEADBEEF00000000);
        drive(1'b0, 10'h000, 1'b0, 32'd0, 1'b1, 1'b0); tick();
        check("t3_noop", 64'(fifo_count1), 64'd1);

        // back-pressure with gnt held low, then drain in order
        drive(1'b1, 10'h100, 1'b0, 32'd0, 1'b0, 1'b0); tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 10'h000, 1'b1, 32'(k), 1'b0, 1'b0); tick();
            if (k == 4) check("t4_not_ready", 64'(in_ready0), 64'd0);
        end
        check("t4_ovf", 64'(overflow0), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("t4_order", 64'(sram_wdata0), 64'(k + 1));
            check("t4_addr", 64'(sram_addr0), 64'(10'h100 + k));
            drive(1'b0, 10'h000, 1'b0, 32'd0, 1'b0, 1'b1); tick();
        end

        // address wrap
        drive(1'b1, 10'h3FF, 1'b0, 32'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 10'h000, 1'b1, 32'h0000_0001, 1'b0, 1'b0); tick();
        drive(1'b0, 10'h000, 1'b1, 32'h0000_0002, 1'b0, 1'b0); tick();
        check("t5_addr_top", 64'(sram_addr0), 64'h3FF);
        drive(1'b0, 10'h000, 1'b0, 32'd0, 1'b0, 1'b1); tick();
        check("t5_addr_wrap", 64'(sram_addr0), 64'h000);

        // asynchronous reset while words are queued
        drive(1'b1, 10'h055, 1'b0, 32'd0, 1'b0, 1'b0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 10'h000, 1'b1, $urandom, 1'b0, 1'b0); tick();
        end
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check("t6_req", 64'(sram_req0), 64'd0);
        check("t6_count", 64'(fifo_count0), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // randomized traffic with varying drain pressure
        for (int c = 0; c < 3000; c++) begin
            int gp;
            case ((c / 100) % 3)
                0:       gp = 10;
                1:       gp = 50;
                default: gp = 90;
            endcase
            drive($urandom_range(0, 39) == 0, 10'($urandom), $urandom_range(0, 9) < 6,
                  $urandom, $urandom_range(0, 6) == 0, $urandom_range(0, 99) < gp);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
